// File: rtl/demux_stream_if.sv
// Stream bundle between one producer, the demultiplexer, and N_OUT consumers.
// The master side is the producer/consumer environment; the slave side is
// the demultiplexer itself.
interface demux_stream_if #(
    parameter int WIDTH = 32,
    parameter int N_OUT = 4
);
    localparam int SELW = $clog2(N_OUT);

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic [SELW-1:0]        in_sel;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    logic [N_OUT*WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux_stream.sv
// Registered valid/ready stream demultiplexer. Each input word is steered to
// one of N_OUT channels by its select. Every channel owns a one-entry holding
// register, so a stalled consumer only blocks words addressed to it. Words
// with an out-of-range select are accepted and discarded, raising sel_err for
// one cycle and bumping a saturating drop counter.
module demux_stream #(
    parameter int WIDTH = 32,
    parameter int N_OUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    demux_stream_if.slave    bus,
    output logic             sel_err,
    output logic [7:0]       drop_count
);
    localparam int SELW = $clog2(N_OUT);

    // Per-channel holding register states
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [N_OUT-1:0]            state_q;
    logic [N_OUT-1:0][WIDTH-1:0] data_q;
    logic [N_OUT-1:0]            sel_hit;
    logic [N_OUT-1:0]            valid;
    logic [N_OUT-1:0]            load;
    logic [N_OUT-1:0]            drain;
    logic                        ready;
    logic                        in_range;
    logic                        accept;
    logic                        discard;

    // Decode the select; an out-of-range select matches no channel and so
    // always sees a ready input and loads nothing
    always_comb begin
        sel_hit = '0;
        valid   = '0;
        ready   = 1'b1;
        for (int k = 0; k < N_OUT; k++) begin
            sel_hit[k] = (bus.in_sel == SELW'(k));
            valid[k]   = (state_q[k] == ST_FULL);
        end
        for (int k = 0; k < N_OUT; k++) begin
            if (sel_hit[k]) begin
                ready = !valid[k] || bus.out_ready[k];
            end
        end
    end

    assign in_range = |sel_hit;
    assign accept   = bus.in_valid && ready;
    assign discard  = accept && !in_range;
    assign load     = sel_hit & {N_OUT{accept}};
    assign drain    = valid & bus.out_ready;

    // Channel state: a load always wins, so drain+load keeps the channel full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (load[k]) begin
                    state_q[k] <= ST_FULL;
                end else if (drain[k]) begin
                    state_q[k] <= ST_EMPTY;
                end
            end
        end
    end

    // Channel data: capture the input word only on a load, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (load[k]) begin
                    data_q[k] <= bus.in_data;
                end
            end
        end
    end

    // Discard reporting: one-cycle error pulse and saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err    <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            sel_err <= discard;
            if (discard && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.out_data  = data_q;
endmodule

// File: tb/tb_demux_stream.sv
// Scoreboard bench for demux_stream: a 4-channel instance carries the main
// routing, backpressure, streaming and reset scenarios, and a 3-channel
// instance exercises out-of-range select discarding.
module tb_demux_stream;
    logic       clk;
    logic       rst;
    logic       sel_err4;
    logic [7:0] drop4;
    logic       sel_err3;
    logic [7:0] drop3;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] q4 [4][$];

    demux_stream_if #(.WIDTH(32), .N_OUT(4)) bus4 ();
    demux_stream_if #(.WIDTH(32), .N_OUT(3)) bus3 ();

    demux_stream #(.WIDTH(32), .N_OUT(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus4.slave),
        .sel_err    (sel_err4),
        .drop_count (drop4)
    );

    demux_stream #(.WIDTH(32), .N_OUT(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus3.slave),
        .sel_err    (sel_err3),
        .drop_count (drop3)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Present one word for one cycle, starting just after a rising edge
    task automatic applyStimulus(input logic [1:0] sel, input logic [31:0] data,
                                 input logic exp_ready, input string name);
        bus4.in_valid = 1'b1;
        bus4.in_sel   = sel;
        bus4.in_data  = data;
        @(negedge clk);
        checkOutput(name, 128'(bus4.in_ready), 128'(exp_ready));
        @(posedge clk);
        if (exp_ready) q4[sel].push_back(data);
        #1;
    endtask

    task automatic idleCycle();
        bus4.in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every word a consumer takes must be the oldest expected word
    initial begin
        logic [31:0] exp_word;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int k = 0; k < 4; k++) begin
                    if (bus4.out_valid[k] && bus4.out_ready[k]) begin
                        if (q4[k].size() == 0) begin
                            vectors++;
                            errors++;
                            $display("[TB] FAIL ch%0d_unexpected: got %h expected no word",
                                     k, bus4.out_data[k*32 +: 32]);
                        end else begin
                            exp_word = q4[k].pop_front();
                            checkOutput($sformatf("ch%0d_data", k),
                                        128'(bus4.out_data[k*32 +: 32]), 128'(exp_word));
                        end
                    end
                end
            end
        end
    end

    initial begin
        int drained;
        rst            = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.in_sel    = '0;
        bus4.in_data   = '0;
        bus4.out_ready = '0;
        bus3.in_valid  = 1'b0;
        bus3.in_sel    = '0;
        bus3.in_data   = '0;
        bus3.out_ready = '0;

        // Reset state, during and after reset
        #2;
        checkOutput("rst_out_valid", 128'(bus4.out_valid), 128'h0);
        checkOutput("rst_out_data", 128'(bus4.out_data), 128'h0);
        checkOutput("rst_sel_err", 128'(sel_err3), 128'h0);
        checkOutput("rst_drop", 128'(drop3), 128'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("post_rst_out_valid", 128'(bus4.out_valid), 128'h0);

        // Single word to channel 2 with every consumer stalled
        applyStimulus(2'd2, 32'hDEADBEEF, 1'b1, "single_ready");
        checkOutput("single_out_valid", 128'(bus4.out_valid), 128'h4);
        checkOutput("single_out_data", 128'(bus4.out_data),
                    128'h00000000_DEADBEEF_00000000_00000000);

        // Backpressure on channel 1 must not block channel 3
        applyStimulus(2'd1, 32'h11111111, 1'b1, "bp_first_ready");
        applyStimulus(2'd1, 32'h22222222, 1'b0, "bp_stall_ready");
        applyStimulus(2'd3, 32'h33333333, 1'b1, "bp_other_ready");
        checkOutput("bp_out_valid", 128'(bus4.out_valid), 128'hE);
        checkOutput("bp_held_word", 128'(bus4.out_data[63:32]), 128'h11111111);
        bus4.out_ready = 4'hF;
        idleCycle();
        checkOutput("bp_drained", 128'(bus4.out_valid), 128'h0);

        // Streaming one word per cycle through channel 0
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2'd0, 32'(i), 1'b1, "stream_ready");
            checkOutput("stream_valid", 128'(bus4.out_valid[0]), 128'h1);
            checkOutput("stream_latency", 128'(bus4.out_data[31:0]), 128'(i));
        end
        idleCycle();
        checkOutput("stream_drained", 128'(bus4.out_valid), 128'h0);

        // Interleaved routing, order preserved per channel
        applyStimulus(2'd3, 32'hAAAA000A, 1'b1, "mix_a_ready");
        applyStimulus(2'd0, 32'hBBBB000B, 1'b1, "mix_b_ready");
        applyStimulus(2'd3, 32'hCCCC000C, 1'b1, "mix_c_ready");
        checkOutput("mix_c_on_ch3", 128'(bus4.out_data[127:96]), 128'hCCCC000C);
        applyStimulus(2'd1, 32'hDDDD000D, 1'b1, "mix_d_ready");
        idleCycle();
        checkOutput("mix_drained", 128'(bus4.out_valid), 128'h0);

        // Asynchronous reset while channels 0 and 2 hold words
        bus4.out_ready = 4'h0;
        applyStimulus(2'd0, 32'h0000C0DE, 1'b1, "ar_ch0_ready");
        applyStimulus(2'd2, 32'h0000BEEF, 1'b1, "ar_ch2_ready");
        bus4.in_valid = 1'b0;
        checkOutput("ar_held", 128'(bus4.out_valid), 128'h5);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_valid_cleared", 128'(bus4.out_valid), 128'h0);
        checkOutput("ar_data_cleared", 128'(bus4.out_data), 128'h0);
        q4[0].delete();
        q4[2].delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(2'd0, 32'h12345678, 1'b1, "ar_after_ready");
        checkOutput("ar_after_valid", 128'(bus4.out_valid), 128'h1);
        checkOutput("ar_after_data", 128'(bus4.out_data[31:0]), 128'h12345678);
        bus4.out_ready = 4'hF;
        idleCycle();

        // Out-of-range select on the 3-channel instance, 300 words back to back
        bus3.out_ready = 3'b111;
        checkOutput("oor_sel_err_idle", 128'(sel_err3), 128'h0);
        for (int i = 0; i < 300; i++) begin
            bus3.in_valid = 1'b1;
            bus3.in_sel   = 2'd3;
            bus3.in_data  = 32'(i);
            @(negedge clk);
            checkOutput("oor_in_ready", 128'(bus3.in_ready), 128'h1);
            checkOutput("oor_out_valid", 128'(bus3.out_valid), 128'h0);
            @(posedge clk);
            #1;
            checkOutput("oor_sel_err", 128'(sel_err3), 128'h1);
            checkOutput("oor_drop", 128'(drop3), 128'((i + 1 > 255) ? 255 : i + 1));
        end
        bus3.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("oor_sel_err_end", 128'(sel_err3), 128'h0);
        checkOutput("oor_drop_end", 128'(drop3), 128'd255);
        checkOutput("oor_no_valid", 128'(bus3.out_valid), 128'h0);

        // Every expected word must have been delivered
        drained = 0;
        while (drained < 20 && (q4[0].size() + q4[1].size() + q4[2].size() + q4[3].size()) != 0) begin
            idleCycle();
            drained++;
        end
        checkOutput("scoreboard_empty",
                    128'(q4[0].size() + q4[1].size() + q4[2].size() + q4[3].size()), 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
